// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C arbiter and the I2C master it feeds:
// default bus widths, arbiter state encoding and a round-robin helper.
package i2c_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 8192;

  // Fixed encodings so that legacy status registers can decode the state.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    WAIT_DONE = ST_WAIT_DONE,
    RESP      = ST_RESP
  } arb_state_t;

  // Next round-robin pointer after index idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester-side and master-side signals of the I2C arbiter in one bundle.
// The master modport is the arbiter's view; the slave modport is the view
// of the requesters and the I2C master sitting around it.
interface i2c_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;

  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;

  logic [IDW-1:0]          grant_id;
  logic                    grant_valid;

  logic                    m_start;
  logic                    m_abort;
  logic [ADDR_W-1:0]       m_addr;
  logic                    m_rw;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_busy;
  logic                    m_done;
  logic                    m_nack;
  logic [DATA_W-1:0]       m_rdata;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata,
    input  m_busy, m_done, m_nack, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output grant_id, grant_valid,
    output m_start, m_abort, m_addr, m_rw, m_wdata
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata,
    output m_busy, m_done, m_nack, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  grant_id, grant_valid,
    input  m_start, m_abort, m_addr, m_rw, m_wdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: starting at ptr_i, scans the request
// vector upward (wrapping) and returns the first requester found as a
// one-hot vector and as an index.
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         grant_oh_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o,
  output logic                     any_o
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic           found;

  // Priority scan from the pointer; first hit wins.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      cand = sum[IDW-1:0];
      if (!found && req_i[cand]) begin
        found             = 1'b1;
        grant_idx_o       = cand;
        grant_oh_o[cand]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master between N_REQ requesters. One transaction at a time,
// round-robin grant, start/done handshake towards the master, watchdog abort
// if the master never reports done, and a one-cycle response pulse back to
// the winning requester.
//
// state     | meaning
// IDLE      | no owner; accept the round-robin winner when any request is up
// START     | owner latched; wait for the master to go idle, then pulse m_start
// WAIT_DONE | transaction in flight; watchdog running
// RESP      | pulse rsp_valid to the owner, advance the pointer past it
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  i2c_arbiter_if.master bus
);

  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              m_start_q, m_start_d;
  logic              m_abort_q, m_abort_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_rw_q, m_rw_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_rr_picker (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  // Next-state and output-register logic for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    m_start_d     = 1'b0;
    m_abort_d     = 1'b0;
    m_addr_d      = m_addr_q;
    m_rw_d        = m_rw_q;
    m_wdata_d     = m_wdata_q;
    timer_d       = timer_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          req_ready_d   = pick_oh;
          m_addr_d      = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
          m_rw_d        = bus.req_rw[pick_idx];
          m_wdata_d     = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d       = START;
        end
      end

      START: begin
        if (!bus.m_busy) begin
          m_start_d = 1'b1;
          timer_d   = '0;
          state_d   = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // Saturate at the last count so the timer can never wrap.
        if (timer_q != TIMER_LAST) begin
          timer_d = timer_q + TW'(1);
        end
        // A done arriving on the timeout cycle still counts as a completion.
        if (bus.m_done) begin
          rsp_rdata_d = m_rw_q ? bus.m_rdata : '0;
          rsp_err_d   = bus.m_nack;
          state_d     = RESP;
        end else if (timer_q == TIMER_LAST) begin
          m_abort_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        rsp_valid_d[grant_id_q] = 1'b1;
        rr_ptr_d      = IDW'(rr_next(32'(grant_id_q), N_REQ));
        grant_valid_d = 1'b0;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; async assert clears everything to the idle picture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      m_start_q     <= 1'b0;
      m_abort_q     <= 1'b0;
      m_addr_q      <= '0;
      m_rw_q        <= 1'b0;
      m_wdata_q     <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      m_start_q     <= m_start_d;
      m_abort_q     <= m_abort_d;
      m_addr_q      <= m_addr_d;
      m_rw_q        <= m_rw_d;
      m_wdata_q     <= m_wdata_d;
      timer_q       <= timer_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.m_start     = m_start_q;
  assign bus.m_abort     = m_abort_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_rw        = m_rw_q;
  assign bus.m_wdata     = m_wdata_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready_q));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid_q));
  a_start_abort:  assert property (@(posedge clk) disable iff (!rst_n) !(m_start_q && m_abort_q));

endmodule
